muldiv_unit: RTL and testbench

Iterative multiply/divide unit implementing the RV32M operations, parametrised in operand width. It sits beside the single-cycle `alu` in the execute stage and takes multi-cycle M-extension work through a valid/ready handshake, so the core can stall on it. It computes one bit per cycle over a `XLEN`-bit datapath. Division by zero and signed overflow are answered on a one-cycle fast path.

---
 rtl/cpu_pkg.sv | 54 +++++
 rtl/muldiv_unit_if.sv | 37 +++
 rtl/muldiv_signfix.sv | 25 ++
 rtl/muldiv_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared execute-stage types and helpers. Holds the M-extension
//               operation encoding (RV32M funct3), the muldiv FSM state type
//               and small decode helpers used by the multiply/divide unit.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Encoding matches RV32M funct3 so decode can pass funct3 straight through.
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_t;

  // funct3[2] separates the divide group from the multiply group.
  function automatic logic is_div(input muldiv_op_t op);
    return op[2];
  endfunction

  function automatic logic is_rem(input muldiv_op_t op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed_a(input muldiv_op_t op);
    case (op)
      MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_b(input muldiv_op_t op);
    case (op)
      MD_MUL, MD_MULH, MD_DIV, MD_REM: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_if
// Description : Request/response bundle between the execute stage and the
//               multiply/divide unit.
// Ports       : master - requester side (drives in_valid/op/a/b/flush/
//                        out_ready, observes in_ready/out_valid/result)
//               slave  - unit side (mirror of master)
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  import cpu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  muldiv_op_t        op;
  logic [XLEN-1:0]   a;
  logic [XLEN-1:0]   b;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   result;

  modport master (
    output in_valid, op, a, b, flush, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, a, b, flush, out_ready,
    output in_ready, out_valid, result
  );

endinterface
`default_nettype wire

// File: rtl/muldiv_signfix.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_signfix
// Description : Conditional two's-complement negate. Used on the way in to
//               turn signed operands into magnitudes, and on the way out to
//               re-apply the result sign.
// Ports       : val_i [WIDTH] - value
//               neg_i         - negate when high
//               val_o [WIDTH] - val_i or -val_i (modulo 2^WIDTH)
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] val_o
);

  // The most-negative value maps to itself, which read as unsigned is the
  // correct magnitude 2^(WIDTH-1).
  assign val_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit, one bit per cycle.
//               Shift-add multiply and restoring divide share one 2*XLEN
//               working register; divide-by-zero and signed overflow take a
//               one-cycle fast path.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous reset, active low
//               bus   - muldiv_unit_if.slave: in_valid/in_ready/op/a/b
//                       request, flush, out_valid/out_ready/result response
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_unit_if.slave  bus
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  muldiv_state_t     state_q, state_d;
  muldiv_op_t        op_q, op_d;
  logic [2*XLEN-1:0] prod_q, prod_d;   // mul: {acc, multiplier}; div: {rem, dividend/quotient}
  logic [XLEN-1:0]   bmag_q, bmag_d;
  logic              neg_q, neg_d;
  logic              fast_q, fast_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  // --------------------------------------------------------------------------
  // Input decode and magnitudes
  // --------------------------------------------------------------------------
  logic            sa, sb;
  logic [XLEN-1:0] amag, bmag;
  logic            b_zero, ovf, fast;
  logic [XLEN-1:0] fast_res;
  logic            req_neg;

  assign sa = is_signed_a(bus.op) & bus.a[XLEN-1];
  assign sb = is_signed_b(bus.op) & bus.b[XLEN-1];

  muldiv_signfix #(.WIDTH(XLEN)) u_fix_a (
    .val_i (bus.a),
    .neg_i (sa),
    .val_o (amag)
  );

  muldiv_signfix #(.WIDTH(XLEN)) u_fix_b (
    .val_i (bus.b),
    .neg_i (sb),
    .val_o (bmag)
  );

  assign b_zero = (bus.b == '0);
  assign ovf    = ((bus.op == MD_DIV) || (bus.op == MD_REM)) &&
                  (bus.a == MOST_NEG) && (bus.b == '1);
  assign fast   = is_div(bus.op) && (b_zero || ovf);

  always_comb begin
    fast_res = '0;
    if (b_zero) begin
      fast_res = is_rem(bus.op) ? bus.a : '1;
    end else begin
      fast_res = is_rem(bus.op) ? '0 : MOST_NEG;
    end
  end

  // Remainder takes the dividend's sign; product and quotient take sa^sb.
  assign req_neg = is_rem(bus.op) ? sa : (sa ^ sb);

  // --------------------------------------------------------------------------
  // One iteration of each algorithm
  // --------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;

  // Add the multiplicand into the upper half when the current multiplier bit
  // is set, then shift the whole register (carry included) right by one.
  assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                    (prod_q[0] ? {1'b0, bmag_q} : {(XLEN+1){1'b0}});
  assign mul_next = {mul_sum, prod_q[XLEN-1:1]};

  // Partial remainder stays below the divisor, so {rem, next dividend bit}
  // fits in XLEN+1 bits and bit XLEN of the difference is the borrow.
  assign div_shift = prod_q[2*XLEN-1:XLEN-1];
  assign div_diff  = div_shift - {1'b0, bmag_q};
  assign div_next  = div_diff[XLEN] ?
                     {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0} :
                     {div_diff[XLEN-1:0],  prod_q[XLEN-2:0], 1'b1};

  // --------------------------------------------------------------------------
  // Output sign fix-up
  // --------------------------------------------------------------------------
  logic [2*XLEN-1:0] fix_in, fix_out;
  logic [XLEN-1:0]   calc_res;

  // Divide results go through the low half so a single 2*XLEN negate serves
  // both the full product and the quotient/remainder.
  always_comb begin
    fix_in = prod_q;
    if (is_div(op_q)) begin
      fix_in = {{XLEN{1'b0}}, (is_rem(op_q) ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0])};
    end
  end

  muldiv_signfix #(.WIDTH(2*XLEN)) u_fix_out (
    .val_i (fix_in),
    .neg_i (neg_q),
    .val_o (fix_out)
  );

  assign calc_res = ((op_q == MD_MUL) || is_div(op_q)) ? fix_out[XLEN-1:0]
                                                       : fix_out[2*XLEN-1:XLEN];

  // --------------------------------------------------------------------------
  // FSM: next state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    prod_d   = prod_q;
    bmag_d   = bmag_q;
    neg_d    = neg_q;
    fast_d   = fast_q;
    result_d = result_q;
    cnt_d    = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.op;
          bmag_d  = bmag;
          fast_d  = fast;
          cnt_d   = '0;
          state_d = ST_CALC;
          if (fast) begin
            // Fast-path answer is already final; park it in the low half
            // and spend exactly one cycle before presenting it.
            prod_d = {{XLEN{1'b0}}, fast_res};
            neg_d  = 1'b0;
          end else begin
            prod_d = {{XLEN{1'b0}}, amag};
            neg_d  = req_neg;
          end
        end
      end

      ST_CALC: begin
        if (fast_q) begin
          result_d = prod_q[XLEN-1:0];
          state_d  = ST_DONE;
        end else if (cnt_q == CW'(XLEN)) begin
          result_d = calc_res;
          state_d  = ST_DONE;
        end else begin
          prod_d = is_div(op_q) ? div_next : mul_next;
          cnt_d  = cnt_q + CW'(1);
        end
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Kill overrides every other transition, including an output handshake.
    if (bus.flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      fast_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= MD_MUL;
      prod_q   <= '0;
      bmag_q   <= '0;
      neg_q    <= 1'b0;
      fast_q   <= 1'b0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      prod_q   <= prod_d;
      bmag_q   <= bmag_d;
      neg_q    <= neg_d;
      fast_q   <= fast_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs, decoded from registered state only
  // --------------------------------------------------------------------------
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit (XLEN=32):
//               multiply/divide results, latency, fast path, backpressure,
//               asynchronous reset and flush aborts.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
  import cpu_pkg::*;

  localparam int XLEN    = 32;
  localparam int LAT     = XLEN + 1;
  localparam int TIMEOUT = 100;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  muldiv_unit_if #(.XLEN(XLEN)) bus ();

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge (E0); returns #1 after E0.
  task automatic issue(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    check("in_ready_before_issue", {31'd0, bus.in_ready}, 32'd1);
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Count edges after E0 until out_valid, tracking whether in_ready stayed low.
  task automatic wait_valid(output int n, output logic rdy_seen);
    n        = 0;
    rdy_seen = 1'b0;
    while (!bus.out_valid && n < TIMEOUT) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input muldiv_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int   n;
    logic rdy_seen;
    issue(op, a, b);
    wait_valid(n, rdy_seen);
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_ready_low"}, {31'd0, rdy_seen}, 32'd0);
    check({tag, "_result"}, bus.result, exp);
    @(posedge clk);
    #1;
    check({tag, "_ready_after"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    int   n;
    logic rdy_seen;
    n_assert      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = MD_MUL;
    bus.a         = '0;
    bus.b         = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Multiply
    run_op("mul",    MD_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT);
    run_op("mulh",   MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, LAT);
    run_op("mulhu",  MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT);
    run_op("mulhsu", MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT);

    // Divide / remainder
    run_op("div",  MD_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, LAT);
    run_op("rem",  MD_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, LAT);
    run_op("divu", MD_DIVU, 32'd100,      32'd7, 32'd14,       LAT);
    run_op("remu", MD_REMU, 32'd100,      32'd7, 32'd2,        LAT);

    // Fast path
    run_op("div0",    MD_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("rem0",    MD_REM,  32'd5,        32'd0,        32'd5,        1);
    run_op("divu0",   MD_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("div_ovf", MD_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf", MD_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // Backpressure: hold result for 5 cycles in DONE
    bus.out_ready = 1'b0;
    issue(MD_DIVU, 32'd100, 32'd7);
    wait_valid(n, rdy_seen);
    check("bp_latency", n, LAT);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_result_hold", bus.result, 32'd14);
      check("bp_valid_hold", {31'd0, bus.out_valid}, 32'd1);
      check("bp_ready_low", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_ready_after", {31'd0, bus.in_ready}, 32'd1);
    check("bp_valid_after", {31'd0, bus.out_valid}, 32'd0);
    run_op("bp_next", MD_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, LAT);

    // Asynchronous reset at iteration 10
    issue(MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
    end
    check("arst_busy", {31'd0, bus.in_ready}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("arst_result", bus.result, 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("arst_divu", MD_DIVU, 32'd9, 32'd3, 32'd3, LAT);

    // Flush mid-CALC
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
    end
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    run_op("flush_divu", MD_DIVU, 32'd9, 32'd3, 32'd3, LAT);

    // Flush coinciding with an output handshake
    issue(MD_REMU, 32'd100, 32'd7);
    wait_valid(n, rdy_seen);
    check("fh_result", bus.result, 32'd2);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("fh_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("fh_out_valid", {31'd0, bus.out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
